cs_ctrl: RTL and testbench

CS_CTRL -- requirements
Module: cs_ctrl

---
 rtl/cs_ctrl_if.sv | 41 ++++
 rtl/cs_ctrl.sv | 154 +++++++++++++++
 tb/tb_cs_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cs_ctrl_if.sv
// Command, handshake and status bundle between cs_ctrl and its peripherals.
// master = the controller side, slave = the peripheral/host side.
interface cs_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             fs_udp_rx;
   logic             fd_udp_rx;
   logic             cmd_mode;
   logic             cmd_stop;
   logic [CNT_W-1:0] pkt_num;
   logic             fs_adc;
   logic             fs_cfg;
   logic             fd_cfg;
   logic             fs_adc_check;
   logic             fd_adc_check;
   logic             fs_adc_conf;
   logic             fd_adc_conf;
   logic             fs_adc_read;
   logic             fd_adc_read;
   logic             fs_udp_tx;
   logic             fd_udp_tx;
   logic [2:0]       dev_num;
   logic [CNT_W-1:0] pkt_cnt;
   logic             busy;
   logic             err;
   logic [1:0]       err_code;

   modport master (
      input  fs_udp_rx, cmd_mode, cmd_stop, pkt_num, fs_adc,
      input  fd_cfg, fd_adc_check, fd_adc_conf, fd_adc_read, fd_udp_tx,
      output fd_udp_rx, fs_cfg, fs_adc_check, fs_adc_conf, fs_adc_read, fs_udp_tx,
      output dev_num, pkt_cnt, busy, err, err_code
   );

   modport slave (
      output fs_udp_rx, cmd_mode, cmd_stop, pkt_num, fs_adc,
      output fd_cfg, fd_adc_check, fd_adc_conf, fd_adc_read, fd_udp_tx,
      input  fd_udp_rx, fs_cfg, fs_adc_check, fs_adc_conf, fs_adc_read, fs_udp_tx,
      input  dev_num, pkt_cnt, busy, err, err_code
   );
endinterface

// File: rtl/cs_ctrl.sv
// Acquisition controller: configures the ADC chain, polls devices round-robin on
// each sample strobe and hands full packets to a parallel UDP transmit FSM.
module cs_ctrl #(
   parameter int DEV_CNT = 4,
   parameter int CNT_W   = 8,
   parameter int TO_MAX  = 1000
) (
   input  logic      clk,
   input  logic      rst,
   cs_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, CFG, CHECK, CONF, WAIT, READ, DONE, ERR} state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

   localparam logic [15:0] TO_LAST  = 16'(TO_MAX - 1);
   localparam logic [2:0]  DEV_LAST = 3'(DEV_CNT - 1);

   state_t           state_q, state_d;
   tx_state_t        tx_q, tx_d;
   logic [2:0]       dev_q, dev_d;
   logic [CNT_W-1:0] pkt_q, pkt_d;
   logic [1:0]       code_q, code_d;
   logic [15:0]      to_q, to_d;
   logic [15:0]      tx_to_q, tx_to_d;
   logic             sent_q, sent_d;
   logic             adc_prev_q, rx_prev_q;

   logic             rx_rise, adc_rise, idle_like, accept, hs_active, hs_done;
   logic             rd_done, pkt_ready, to_hit, ovf, tx_hit;
   logic [CNT_W-1:0] pkt_lim, pkt_inc;

   assign rx_rise   = bus.fs_udp_rx & ~rx_prev_q;
   assign adc_rise  = bus.fs_adc & ~adc_prev_q;
   assign idle_like = state_q inside {IDLE, DONE, ERR};
   assign accept    = idle_like & rx_rise;
   assign hs_active = state_q inside {CFG, CHECK, CONF, READ};
   assign pkt_lim   = (bus.pkt_num == '0) ? CNT_W'(1) : bus.pkt_num;
   assign pkt_inc   = pkt_q + CNT_W'(1);
   assign rd_done   = (state_q == READ) & bus.fd_adc_read;
   assign pkt_ready = rd_done & (pkt_inc == pkt_lim);
   assign ovf       = pkt_ready & (tx_q == TX_SEND);
   assign to_hit    = hs_active & ~hs_done & (to_q == TO_LAST);
   assign tx_hit    = (tx_q == TX_SEND) & ~bus.fd_udp_tx & (tx_to_q == TO_LAST);

   always_comb begin
      hs_done = 1'b0;
      case (state_q)
         CFG:     hs_done = bus.fd_cfg;
         CHECK:   hs_done = bus.fd_adc_check;
         CONF:    hs_done = bus.fd_adc_conf;
         READ:    hs_done = bus.fd_adc_read;
         default: hs_done = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      dev_d   = dev_q;
      pkt_d   = pkt_q;
      code_d  = code_q;
      sent_d  = sent_q;

      case (tx_q)
         TX_IDLE: if (pkt_ready) tx_d = TX_SEND;
         TX_SEND: if (bus.fd_udp_tx) begin
            tx_d   = TX_IDLE;
            sent_d = 1'b1;
         end
         default: tx_d = TX_IDLE;
      endcase
      if (tx_hit) tx_d = TX_IDLE;

      case (state_q)
         IDLE, DONE, ERR: if (rx_rise) begin
            state_d = CFG;
            dev_d   = '0;
            pkt_d   = '0;
            code_d  = '0;
            tx_d    = TX_IDLE;
            sent_d  = 1'b0;
         end
         CFG:   if (bus.fd_cfg)       state_d = CHECK;
         CHECK: if (bus.fd_adc_check) state_d = CONF;
         CONF:  if (bus.fd_adc_conf)  state_d = WAIT;
         // Leaving WAIT for DONE takes priority over starting another read.
         WAIT: begin
            if ((bus.cmd_stop && tx_q == TX_IDLE) || (bus.cmd_mode && sent_q))
               state_d = DONE;
            else if (adc_rise)
               state_d = READ;
         end
         READ: if (bus.fd_adc_read) begin
            state_d = WAIT;
            dev_d   = (dev_q == DEV_LAST) ? '0 : dev_q + 3'd1;
            pkt_d   = pkt_ready ? '0 : pkt_inc;
         end
         default: state_d = IDLE;
      endcase

      // Error causes ranked: handshake timeout, then overflow, then TX timeout.
      if (to_hit) begin
         state_d = ERR;
         code_d  = 2'd1;
      end else if (ovf) begin
         state_d = ERR;
         code_d  = 2'd3;
      end else if (tx_hit && state_q != ERR && !accept) begin
         state_d = ERR;
         code_d  = 2'd2;
      end

      to_d    = (state_d == state_q && hs_active) ? to_q + 16'd1 : '0;
      tx_to_d = (tx_q == TX_SEND && tx_d == TX_SEND) ? tx_to_q + 16'd1 : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         tx_q       <= TX_IDLE;
         dev_q      <= '0;
         pkt_q      <= '0;
         code_q     <= '0;
         to_q       <= '0;
         tx_to_q    <= '0;
         sent_q     <= 1'b0;
         adc_prev_q <= 1'b1;
         rx_prev_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         dev_q      <= dev_d;
         pkt_q      <= pkt_d;
         code_q     <= code_d;
         to_q       <= to_d;
         tx_to_q    <= tx_to_d;
         sent_q     <= sent_d;
         adc_prev_q <= bus.fs_adc;
         rx_prev_q  <= bus.fs_udp_rx;
      end
   end

   assign bus.fd_udp_rx    = accept;
   assign bus.fs_cfg       = (state_q == CFG);
   assign bus.fs_adc_check = (state_q == CHECK);
   assign bus.fs_adc_conf  = (state_q == CONF);
   assign bus.fs_adc_read  = (state_q == READ);
   assign bus.fs_udp_tx    = (tx_q == TX_SEND);
   assign bus.dev_num      = dev_q;
   assign bus.pkt_cnt      = pkt_q;
   assign bus.busy         = ~idle_like;
   assign bus.err          = (state_q == ERR);
   assign bus.err_code     = code_q;
endmodule

// File: tb/tb_cs_ctrl.sv
// Scoreboard bench for cs_ctrl: directed scenarios push expected events, an
// independent monitor pops them as the DUT produces handshakes and status edges.
module tb_cs_ctrl;
   localparam int TO_MAX_TB = 20;
   localparam int EV_RXACK = 0, EV_READ = 1, EV_TX = 2, EV_ERR = 3, EV_DONE = 4;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] hold = '0;
   int         checks = 0;
   int         errors = 0;
   ev_t        exp_q[$];
   logic       busy_p = 1'b0;
   logic       err_p = 1'b0;

   cs_ctrl_if #(.CNT_W(8)) bus ();

   cs_ctrl #(.DEV_CNT(4), .CNT_W(8), .TO_MAX(TO_MAX_TB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic expect_ev(input int k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic got(input int k, input int v);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: actual kind %0d value %0d required none", k, v);
      end else begin
         e = exp_q.pop_front();
         if (e.val < 0) chk("event_kind", k, e.kind);
         else           chk("event_kind_value", k * 4096 + v, e.kind * 4096 + e.val);
      end
   endtask

   function automatic int outs();
      return int'({bus.fs_cfg, bus.fs_adc_check, bus.fs_adc_conf, bus.fs_adc_read,
                   bus.fs_udp_tx, bus.fd_udp_rx, bus.busy, bus.err, bus.err_code,
                   bus.dev_num, bus.pkt_cnt});
   endfunction

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic rx_rise();
      expect_ev(EV_RXACK, -1);
      bus.fs_udp_rx = 1'b1;
      cyc(3);
      bus.fs_udp_rx = 1'b0;
   endtask

   task automatic adc_edge(input int gap);
      bus.fs_adc = 1'b1;
      cyc(2);
      bus.fs_adc = 1'b0;
      cyc(gap);
   endtask

   task automatic stop_to_done();
      expect_ev(EV_DONE, -1);
      bus.cmd_stop = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 40 && bus.busy; k++) @(negedge clk);
      chk("stop_busy", int'(bus.busy), 0);
      cyc(1);
      bus.cmd_stop = 1'b0;
   endtask

   // Peripheral model: each asserted fs_x is answered with a one-cycle fd_x two cycles later.
   initial begin
      logic [4:0] fs;
      logic [4:0] fd;
      int         rcnt[5];
      fd = '0;
      for (int i = 0; i < 5; i++) rcnt[i] = 0;
      {bus.fd_udp_tx, bus.fd_adc_read, bus.fd_adc_conf, bus.fd_adc_check, bus.fd_cfg} = fd;
      forever begin
         @(posedge clk);
         #2;
         fs = {bus.fs_udp_tx, bus.fs_adc_read, bus.fs_adc_conf, bus.fs_adc_check, bus.fs_cfg};
         for (int i = 0; i < 5; i++) begin
            if (fd[i]) begin
               fd[i]   = 1'b0;
               rcnt[i] = 0;
            end else if (fs[i] && !hold[i]) begin
               rcnt[i]++;
               if (rcnt[i] >= 2) fd[i] = 1'b1;
            end else begin
               rcnt[i] = 0;
            end
         end
         {bus.fd_udp_tx, bus.fd_adc_read, bus.fd_adc_conf, bus.fd_adc_check, bus.fd_cfg} = fd;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (bus.fd_udp_rx) got(EV_RXACK, 0);
            if (bus.fs_adc_read && bus.fd_adc_read)
               got(EV_READ, int'(bus.dev_num) * 256 + int'(bus.pkt_cnt));
            if (bus.fs_udp_tx && bus.fd_udp_tx) got(EV_TX, 0);
            if (bus.err && !err_p) got(EV_ERR, int'(bus.err_code));
            if (busy_p && !bus.busy && !bus.err) got(EV_DONE, 0);
         end
         busy_p = bus.busy;
         err_p  = bus.err;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

   initial begin
      int n;
      bus.fs_udp_rx = 1'b0;
      bus.cmd_mode  = 1'b0;
      bus.cmd_stop  = 1'b0;
      bus.pkt_num   = 8'd3;
      bus.fs_adc    = 1'b0;
      cyc(3);
      chk("reset_outputs", outs(), 0);
      rst = 1'b1;
      cyc(2);

      // Continuous mode, 6 reads, packets of 3
      rx_rise();
      cyc(12);
      for (int i = 0; i < 6; i++) begin
         expect_ev(EV_READ, (i % 4) * 256 + (i % 3));
         if (i % 3 == 2) expect_ev(EV_TX, -1);
         adc_edge(8);
      end
      chk("a_dev_num", int'(bus.dev_num), 2);
      chk("a_pkt_cnt", int'(bus.pkt_cnt), 0);
      stop_to_done();

      // Single-shot, packets of 2
      bus.cmd_mode = 1'b1;
      bus.pkt_num  = 8'd2;
      rx_rise();
      cyc(12);
      expect_ev(EV_READ, 0 * 256 + 0);
      adc_edge(8);
      expect_ev(EV_READ, 1 * 256 + 1);
      expect_ev(EV_TX, -1);
      expect_ev(EV_DONE, -1);
      adc_edge(8);
      cyc(5);
      chk("b_busy", int'(bus.busy), 0);
      adc_edge(8);
      adc_edge(8);
      chk("b_dev_num", int'(bus.dev_num), 2);

      // Handshake timeout on CONF
      bus.cmd_mode = 1'b0;
      bus.pkt_num  = 8'd3;
      hold[2] = 1'b1;
      rx_rise();
      expect_ev(EV_ERR, 1);
      @(negedge clk);
      for (int k = 0; k < 30 && !bus.fs_adc_conf; k++) @(negedge clk);
      n = 0;
      while (bus.fs_adc_conf && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("c_conf_len", n, TO_MAX_TB);
      chk("c_err", int'(bus.err), 1);
      chk("c_err_code", int'(bus.err_code), 1);
      chk("c_fs_conf", int'(bus.fs_adc_conf), 0);
      hold[2] = 1'b0;
      cyc(1);
      expect_ev(EV_RXACK, -1);
      bus.fs_udp_rx = 1'b1;
      @(posedge clk);
      #1;
      chk("c_err_cleared", int'(bus.err), 0);
      chk("c_cfg_entered", int'(bus.fs_cfg), 1);
      #1;
      cyc(2);
      bus.fs_udp_rx = 1'b0;
      cyc(12);
      stop_to_done();

      // Overflow: second packet while the first is still sending
      bus.pkt_num = 8'd1;
      rx_rise();
      cyc(12);
      hold[4] = 1'b1;
      expect_ev(EV_READ, 0 * 256 + 0);
      adc_edge(5);
      expect_ev(EV_READ, 1 * 256 + 0);
      expect_ev(EV_ERR, 3);
      adc_edge(0);
      @(negedge clk);
      for (int k = 0; k < 20 && !bus.err; k++) @(negedge clk);
      chk("d_err_code", int'(bus.err_code), 3);
      cyc(1);
      expect_ev(EV_TX, -1);
      hold[4] = 1'b0;
      cyc(6);
      chk("d_fs_tx", int'(bus.fs_udp_tx), 0);

      // TX timeout
      hold[4] = 1'b1;
      rx_rise();
      cyc(12);
      expect_ev(EV_READ, 0 * 256 + 0);
      expect_ev(EV_ERR, 2);
      adc_edge(0);
      @(negedge clk);
      for (int k = 0; k < 30 && !bus.fs_udp_tx; k++) @(negedge clk);
      n = 0;
      while (bus.fs_udp_tx && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("e_tx_len", n, TO_MAX_TB);
      chk("e_err", int'(bus.err), 1);
      chk("e_err_code", int'(bus.err_code), 2);
      hold[4] = 1'b0;
      cyc(1);

      // pkt_num 0: every read is a packet; stop waits for TX
      bus.pkt_num = 8'd0;
      rx_rise();
      cyc(12);
      expect_ev(EV_READ, 0 * 256 + 0);
      expect_ev(EV_TX, -1);
      adc_edge(8);
      hold[4] = 1'b1;
      expect_ev(EV_READ, 1 * 256 + 0);
      adc_edge(5);
      bus.cmd_stop = 1'b1;
      cyc(4);
      chk("f_busy_during_tx", int'(bus.busy), 1);
      expect_ev(EV_TX, -1);
      expect_ev(EV_DONE, -1);
      hold[4] = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
      chk("f_busy_after_tx", int'(bus.busy), 0);
      cyc(1);
      bus.cmd_stop = 1'b0;

      // Reset mid-READ with the strobe held high through release
      bus.pkt_num = 8'd3;
      rx_rise();
      cyc(12);
      hold[3] = 1'b1;
      bus.fs_adc = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 10 && !bus.fs_adc_read; k++) @(negedge clk);
      chk("g_in_read", int'(bus.fs_adc_read), 1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("g_read_dropped", int'(bus.fs_adc_read), 0);
      chk("g_reset_outputs", outs(), 0);
      cyc(3);
      hold[3] = 1'b0;
      rst = 1'b1;
      cyc(3);
      rx_rise();
      cyc(12);
      chk("g_no_read", int'(bus.fs_adc_read), 0);
      bus.fs_adc = 1'b0;
      cyc(2);
      expect_ev(EV_READ, 0 * 256 + 0);
      adc_edge(8);
      stop_to_done();

      cyc(10);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
